// File: rtl/ccip_mux_bridge_if.sv
// Bundle of every signal between the CCI-P mux bridge, its memory clients and the
// c0/c1 Tx/Rx header packing. "slave" is the bridge's view, "master" the surroundings.
interface ccip_mux_bridge_if #(
  parameter int NUM_RD  = 4,
  parameter int NUM_WR  = 4,
  parameter int TAG_W   = 8,
  parameter int MAX_OUT = 64,
  parameter int ADDR_W  = 64
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  // Handshake: a client request transfers on a clock edge where valid[i] & ready[i]
  // are both high. ready is combinational, at most one bit set, and a client keeps
  // valid, addr, tag and data stable until it sees ready. Responses and c0/c1 Tx
  // valids are single-cycle pulses with no back-pressure.
  logic [NUM_RD-1:0]        rd_req_valid;
  logic [NUM_RD*ADDR_W-1:0] rd_req_addr;
  logic [NUM_RD*TAG_W-1:0]  rd_req_tag;
  logic [NUM_RD-1:0]        rd_req_ready;
  logic [NUM_RD-1:0]        rd_rsp_valid;
  logic [TAG_W-1:0]         rd_rsp_tag;
  logic [511:0]             rd_rsp_data;

  logic [NUM_WR-1:0]        wr_req_valid;
  logic [NUM_WR*ADDR_W-1:0] wr_req_addr;
  logic [NUM_WR*TAG_W-1:0]  wr_req_tag;
  logic [NUM_WR*512-1:0]    wr_req_data;
  logic [NUM_WR-1:0]        wr_req_ready;
  logic [NUM_WR-1:0]        wr_rsp_valid;
  logic [TAG_W-1:0]         wr_rsp_tag;

  logic                     c0_almfull;
  logic                     c0_valid;
  logic [ADDR_W-1:0]        c0_addr;
  logic [15:0]              c0_mdata;
  logic                     c0_rsp_valid;
  logic [15:0]              c0_rsp_mdata;
  logic [511:0]             c0_rsp_data;

  logic                     c1_almfull;
  logic                     c1_valid;
  logic [ADDR_W-1:0]        c1_addr;
  logic [15:0]              c1_mdata;
  logic [511:0]             c1_data;
  logic                     c1_rsp_valid;
  logic [15:0]              c1_rsp_mdata;

  logic [CNT_W-1:0]         rd_outstanding;
  logic [CNT_W-1:0]         wr_outstanding;
  logic [1:0]               err_sticky;

  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_tag,
    output rd_req_ready, rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
    input  wr_req_valid, wr_req_addr, wr_req_tag, wr_req_data,
    output wr_req_ready, wr_rsp_valid, wr_rsp_tag,
    input  c0_almfull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    output c0_valid, c0_addr, c0_mdata,
    input  c1_almfull, c1_rsp_valid, c1_rsp_mdata,
    output c1_valid, c1_addr, c1_mdata, c1_data,
    output rd_outstanding, wr_outstanding, err_sticky
  );

  modport master (
    output rd_req_valid, rd_req_addr, rd_req_tag,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
    output wr_req_valid, wr_req_addr, wr_req_tag, wr_req_data,
    input  wr_req_ready, wr_rsp_valid, wr_rsp_tag,
    output c0_almfull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
    input  c0_valid, c0_addr, c0_mdata,
    output c1_almfull, c1_rsp_valid, c1_rsp_mdata,
    input  c1_valid, c1_addr, c1_mdata, c1_data,
    input  rd_outstanding, wr_outstanding, err_sticky
  );
endinterface

// File: rtl/ccip_mux_bridge.sv
// Round-robin mux of NUM_RD read and NUM_WR write clients onto CCI-P c0/c1 Tx, with
// client-ID tagging in mdata, response routing and per-channel in-flight limits.
module ccip_mux_bridge #(
  parameter int NUM_RD  = 4,
  parameter int NUM_WR  = 4,
  parameter int TAG_W   = 8,
  parameter int MAX_OUT = 64,
  parameter int ADDR_W  = 64
) (
  input  logic                clk,
  input  logic                SoftReset,
  ccip_mux_bridge_if.slave    bus
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int RD_IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int WR_IW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  // ---------------- c0 read path ----------------
  logic [RD_IW-1:0] rd_ptr;
  logic [RD_IW-1:0] rd_win;
  logic             rd_found;
  logic             rd_fire;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_err;
  logic [15:0]      rd_mdata_next;
  logic [15:0]      rd_rsp_cid;
  logic             rd_rsp_ok;

  always_comb begin
    rd_found = 1'b0;
    rd_win   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!rd_found && bus.rd_req_valid[(int'(rd_ptr) + k) % NUM_RD]) begin
        rd_found = 1'b1;
        rd_win   = RD_IW'((int'(rd_ptr) + k) % NUM_RD);
      end
    end
    rd_fire = !SoftReset && !bus.c0_almfull && (rd_cnt < MAX_CNT) && rd_found;
    bus.rd_req_ready = '0;
    if (rd_fire) bus.rd_req_ready[rd_win] = 1'b1;
  end

  always_comb begin
    rd_mdata_next = '0;
    rd_mdata_next[TAG_W-1:0]     = bus.rd_req_tag[rd_win*TAG_W +: TAG_W];
    rd_mdata_next[TAG_W +: RD_IW] = rd_win;
  end

  // The whole field above the tag is the client ID, so a nonzero pad is out of range.
  assign rd_rsp_cid = bus.c0_rsp_mdata >> TAG_W;
  assign rd_rsp_ok  = rd_rsp_cid < 16'(NUM_RD);

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      rd_ptr           <= '0;
      rd_cnt           <= '0;
      rd_err           <= 1'b0;
      bus.c0_valid     <= 1'b0;
      bus.c0_addr      <= '0;
      bus.c0_mdata     <= '0;
      bus.rd_rsp_valid <= '0;
      bus.rd_rsp_tag   <= '0;
      bus.rd_rsp_data  <= '0;
    end else begin
      bus.c0_valid <= rd_fire;
      if (rd_fire) begin
        bus.c0_addr  <= bus.rd_req_addr[rd_win*ADDR_W +: ADDR_W];
        bus.c0_mdata <= rd_mdata_next;
        rd_ptr       <= (rd_win == RD_IW'(NUM_RD - 1)) ? '0 : rd_win + RD_IW'(1);
      end
      bus.rd_rsp_valid <= '0;
      if (bus.c0_rsp_valid) begin
        if (rd_rsp_ok) begin
          bus.rd_rsp_valid[rd_rsp_cid[RD_IW-1:0]] <= 1'b1;
          bus.rd_rsp_tag  <= bus.c0_rsp_mdata[TAG_W-1:0];
          bus.rd_rsp_data <= bus.c0_rsp_data;
        end
        if (!rd_rsp_ok || rd_cnt == '0) rd_err <= 1'b1;
      end
      // A response against an empty counter saturates at zero.
      if (rd_fire && !bus.c0_rsp_valid)
        rd_cnt <= rd_cnt + CNT_W'(1);
      else if (!rd_fire && bus.c0_rsp_valid && rd_cnt != '0)
        rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

  // ---------------- c1 write path ----------------
  logic [WR_IW-1:0] wr_ptr;
  logic [WR_IW-1:0] wr_win;
  logic             wr_found;
  logic             wr_fire;
  logic [CNT_W-1:0] wr_cnt;
  logic             wr_err;
  logic [15:0]      wr_mdata_next;
  logic [15:0]      wr_rsp_cid;
  logic             wr_rsp_ok;

  always_comb begin
    wr_found = 1'b0;
    wr_win   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (!wr_found && bus.wr_req_valid[(int'(wr_ptr) + k) % NUM_WR]) begin
        wr_found = 1'b1;
        wr_win   = WR_IW'((int'(wr_ptr) + k) % NUM_WR);
      end
    end
    wr_fire = !SoftReset && !bus.c1_almfull && (wr_cnt < MAX_CNT) && wr_found;
    bus.wr_req_ready = '0;
    if (wr_fire) bus.wr_req_ready[wr_win] = 1'b1;
  end

  always_comb begin
    wr_mdata_next = '0;
    wr_mdata_next[TAG_W-1:0]     = bus.wr_req_tag[wr_win*TAG_W +: TAG_W];
    wr_mdata_next[TAG_W +: WR_IW] = wr_win;
  end

  assign wr_rsp_cid = bus.c1_rsp_mdata >> TAG_W;
  assign wr_rsp_ok  = wr_rsp_cid < 16'(NUM_WR);

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      wr_ptr           <= '0;
      wr_cnt           <= '0;
      wr_err           <= 1'b0;
      bus.c1_valid     <= 1'b0;
      bus.c1_addr      <= '0;
      bus.c1_mdata     <= '0;
      bus.c1_data      <= '0;
      bus.wr_rsp_valid <= '0;
      bus.wr_rsp_tag   <= '0;
    end else begin
      bus.c1_valid <= wr_fire;
      if (wr_fire) begin
        bus.c1_addr  <= bus.wr_req_addr[wr_win*ADDR_W +: ADDR_W];
        bus.c1_mdata <= wr_mdata_next;
        bus.c1_data  <= bus.wr_req_data[wr_win*512 +: 512];
        wr_ptr       <= (wr_win == WR_IW'(NUM_WR - 1)) ? '0 : wr_win + WR_IW'(1);
      end
      bus.wr_rsp_valid <= '0;
      if (bus.c1_rsp_valid) begin
        if (wr_rsp_ok) begin
          bus.wr_rsp_valid[wr_rsp_cid[WR_IW-1:0]] <= 1'b1;
          bus.wr_rsp_tag <= bus.c1_rsp_mdata[TAG_W-1:0];
        end
        if (!wr_rsp_ok || wr_cnt == '0) wr_err <= 1'b1;
      end
      if (wr_fire && !bus.c1_rsp_valid)
        wr_cnt <= wr_cnt + CNT_W'(1);
      else if (!wr_fire && bus.c1_rsp_valid && wr_cnt != '0)
        wr_cnt <= wr_cnt - CNT_W'(1);
    end
  end

  assign bus.rd_outstanding = rd_cnt;
  assign bus.wr_outstanding = wr_cnt;
  assign bus.err_sticky     = {wr_err, rd_err};

endmodule
